// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one memory.
// Data wins ties; fetch is forced through after STARVE_LIMIT data grants while it waits.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = (STARVE_LIMIT < 3) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve, starve_nxt;
    logic          pick_d, pick_if;

    logic          if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
    logic          mem_en_nxt, mem_we_nxt;
    logic [15:0]   if_rdata_nxt, d_rdata_nxt, mem_addr_nxt, mem_wdata_nxt;

    // Arbitration decision, only acted on in IDLE.
    assign pick_d  = d_req && !(if_req && (starve == LIMIT));
    assign pick_if = if_req && !pick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = BUSY_D;
                end else if (pick_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_nxt    = 1'b0;
        if_valid_nxt  = 1'b0;
        d_gnt_nxt     = 1'b0;
        d_valid_nxt   = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        starve_nxt    = starve;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    d_gnt_nxt     = 1'b1;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    if (if_req && (starve != LIMIT)) begin
                        starve_nxt = starve + 1'b1;
                    end
                end else if (pick_if) begin
                    if_gnt_nxt   = 1'b1;
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = if_addr;
                    starve_nxt   = '0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_nxt = mem_rdata;
                    if_valid_nxt = 1'b1;
                    mem_en_nxt   = 1'b0;
                    mem_we_nxt   = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    // Stores complete without disturbing the last load result.
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                    d_valid_nxt = 1'b1;
                    mem_en_nxt  = 1'b0;
                    mem_we_nxt  = 1'b0;
                end
            end
            default: begin
                mem_en_nxt = 1'b0;
                mem_we_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            starve    <= '0;
        end else begin
            if_gnt    <= if_gnt_nxt;
            if_valid  <= if_valid_nxt;
            if_rdata  <= if_rdata_nxt;
            d_gnt     <= d_gnt_nxt;
            d_valid   <= d_valid_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            starve    <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder, requester drivers, and a monitor that
// checks responses against expectations queued when each request is issued.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_valid;
    logic [15:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] fetch_ref(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA123 : init_val(a);
    endfunction

    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] d_model [logic [15:0]];
    logic [15:0] exp_if_q[$];
    logic [15:0] exp_d_q[$];
    logic [15:0] last_load = 16'h0000;
    bit          gnt_log[$];

    int fixed_delay = 0;
    bit spurious_en = 1'b0;
    bit force_ready = 1'b0;

    // Memory responder with programmable latency; also checks request stability.
    initial begin
        int          cnt;
        bit          busy_seen;
        logic [15:0] a0, w0;
        logic        we0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        busy_seen = 1'b0;
        cnt = 0;
        a0 = '0; w0 = '0; we0 = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (!busy_seen) begin
                    busy_seen = 1'b1;
                    a0  = mem_addr;
                    w0  = mem_wdata;
                    we0 = mem_we;
                    cnt = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
                end else begin
                    check("hold_addr", mem_addr, a0);
                    check("hold_wdata", mem_wdata, w0);
                    check("hold_we", 16'(mem_we), 16'(we0));
                end
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = 16'($urandom);
                    end else begin
                        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_val(mem_addr);
                    end
                end else begin
                    mem_ready = 1'b0;
                    cnt--;
                end
            end else begin
                busy_seen = 1'b0;
                mem_ready = force_ready || (spurious_en && ($urandom_range(0, 2) == 0));
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: every valid pulse consumes one queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (if_valid) begin
                if (exp_if_q.size() == 0) check("if_valid_unexpected", 16'(if_valid), 16'h0);
                else check("if_rdata", if_rdata, exp_if_q.pop_front());
            end
            if (d_valid) begin
                if (exp_d_q.size() == 0) check("d_valid_unexpected", 16'(d_valid), 16'h0);
                else check("d_rdata", d_rdata, exp_d_q.pop_front());
            end
            if (if_gnt || d_gnt) begin
                check("gnt_exclusive", 16'(if_gnt & d_gnt), 16'h0);
                gnt_log.push_back(if_gnt);
            end
        end
    end

    task automatic wait_gnt(input bit is_if);
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = is_if ? if_gnt : d_gnt;
            n++;
        end
        if (!ok) check(is_if ? "if_gnt_timeout" : "d_gnt_timeout", 16'(ok), 16'h1);
    endtask

    task automatic do_fetch(input logic [15:0] a);
        exp_if_q.push_back(fetch_ref(a));
        if_addr = a;
        if_req  = 1'b1;
        wait_gnt(1'b1);
        if_req  = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [15:0] a, input logic [15:0] w);
        logic [15:0] v;
        if (we) begin
            d_model[a] = w;
            exp_d_q.push_back(last_load);
        end else begin
            v = d_model.exists(a) ? d_model[a] : init_val(a);
            last_load = v;
            exp_d_q.push_back(v);
        end
        d_we    = we;
        d_addr  = a;
        d_wdata = w;
        d_req   = 1'b1;
        wait_gnt(1'b0);
        d_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_if_q.size() != 0 || exp_d_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_if", 16'(exp_if_q.size()), 16'h0);
        check("drain_d", 16'(exp_d_q.size()), 16'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit exp_seq [8];
        int n;
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_arr[16'h0010] = 16'hA123;

        #12;
        check("rst_mem_en", 16'(mem_en), 16'h0);
        check("rst_mem_we", 16'(mem_we), 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_if_rdata", if_rdata, 16'h0);
        check("rst_d_rdata", d_rdata, 16'h0);
        check("rst_gnts", 16'({if_gnt, d_gnt, if_valid, d_valid}), 16'h0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Spurious ready in IDLE.
        force_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("spur_mem_en", 16'(mem_en), 16'h0);
            check("spur_valid", 16'({if_valid, d_valid}), 16'h0);
        end
        force_ready = 1'b0;
        idle(1);

        // Single fetch with one-cycle memory latency.
        fixed_delay = 0;
        do_fetch(16'h0010);
        check("fetch_mem_addr", mem_addr, 16'h0010);
        check("fetch_mem_we", 16'(mem_we), 16'h0);
        check("fetch_mem_en", 16'(mem_en), 16'h1);
        @(negedge clk);
        check("fetch_gnt_pulse", 16'(if_gnt), 16'h0);
        check("fetch_valid_lat", 16'(if_valid), 16'h1);
        @(negedge clk);
        check("fetch_valid_pulse", 16'(if_valid), 16'h0);
        idle(1);

        // Load, then store with three-cycle access; load result must survive.
        do_data(1'b0, 16'h0201, 16'h0);
        idle(3);
        fixed_delay = 2;
        do_data(1'b1, 16'h0200, 16'hBEEF);
        n = 0;
        for (int i = 0; i < 50 && !d_valid; i++) begin
            n += int'(mem_we);
            @(negedge clk);
        end
        check("store_we_cycles", 16'(n), 16'd3);
        fixed_delay = 0;
        idle(2);

        // Contention: both held, expect D,D,D,IF repeating.
        for (int i = 0; i < 6; i++) begin
            last_load = d_model.exists(16'h0120) ? d_model[16'h0120] : init_val(16'h0120);
            exp_d_q.push_back(last_load);
        end
        exp_if_q.push_back(fetch_ref(16'h0020));
        exp_if_q.push_back(fetch_ref(16'h0020));
        gnt_log.delete();
        if_addr = 16'h0020; if_req = 1'b1;
        d_addr = 16'h0120; d_we = 1'b0; d_req = 1'b1;
        n = 0;
        while (gnt_log.size() < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if_req = 1'b0; d_req = 1'b0;
        idle(4);
        check("contend_count", 16'(gnt_log.size()), 16'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            check($sformatf("contend_order%0d", i), 16'(gnt_log[i]), 16'(exp_seq[i]));
        end
        drain();

        // Stall: ten low-ready cycles with requester inputs toggling.
        fixed_delay = 10;
        gnt_log.delete();
        do_data(1'b1, 16'h0130, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
            if_addr = 16'($urandom);
            if_req = (i < 9) ? 1'($urandom) : 1'b0;
            d_req  = (i < 9) ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        fixed_delay = 0;
        drain();
        idle(2);
        check("stall_one_grant", 16'(gnt_log.size()), 16'd1);

        // Reset in the middle of a fetch access.
        fixed_delay = 50;
        if_addr = 16'h0040;
        if_req = 1'b1;
        wait_gnt(1'b1);
        if_req = 1'b0;
        idle(2);
        #2 reset = 1'b1;
        #1;
        check("abort_mem_en", 16'(mem_en), 16'h0);
        check("abort_mem_we", 16'(mem_we), 16'h0);
        force_ready = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        last_load = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_if_valid", 16'(if_valid), 16'h0);
            check("abort_mem_en_after", 16'(mem_en), 16'h0);
        end
        force_ready = 1'b0;
        fixed_delay = 0;
        do_fetch(16'h0041);
        do_data(1'b0, 16'h0130, 16'h0);
        drain();

        // Randomized traffic from both requesters.
        fixed_delay = -1;
        spurious_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    do_fetch(16'($urandom_range(0, 255)));
                    idle(int'($urandom_range(0, 3)));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    do_data(1'($urandom), 16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
                    idle(int'($urandom_range(0, 2)));
                end
            end
        join
        drain();
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3; max consecutive data grants while fetch waits.
REQ-002 SHALL have ports:
  clk  input  1  clock; all state changes on rising edge
  reset  input  1  reset, asynchronous, active-high
  if_req  input  1  instruction-fetch request
  if_addr  input  16  fetch word address (pc)
  if_gnt  output  1  one-cycle pulse: fetch request accepted
  if_valid  output  1  one-cycle pulse: if_rdata holds fetched instruction
  if_rdata  output  16  fetched instruction word
  d_req  input  1  data request
  d_we  input  1  1 = store, 0 = load
  d_addr  input  16  data word address
  d_wdata  input  16  store data
  d_gnt  output  1  one-cycle pulse: data request accepted
  d_valid  output  1  one-cycle pulse: load data ready / store complete
  d_rdata  output  16  load data
  mem_en  output  1  memory access active
  mem_we  output  1  memory write strobe
  mem_addr  output  16  memory word address
  mem_wdata  output  16  memory write data
  mem_rdata  input  16  memory read data
  mem_ready  input  1  memory completes access this cycle

Function
REQ-003 SHALL implement states IDLE, BUSY_IF, BUSY_D; all outputs registered.
REQ-004 IDLE, no request: SHALL stay IDLE; mem_en=0.
REQ-005 IDLE, request(s) present at edge: SHALL pick winner per REQ-006, latch its address (and d_we, d_wdata for data) into mem_addr/mem_we/mem_wdata, set mem_en=1, pulse winner's gnt for exactly one cycle, enter BUSY_IF or BUSY_D.
REQ-006 Priority: data wins both-request ties, except fetch wins when starve counter == STARVE_LIMIT.
REQ-007 Starve counter (2+ bits, saturating at STARVE_LIMIT): +1 on each data grant while if_req=1; cleared on every fetch grant.
REQ-008 BUSY_x: mem_en, mem_we, mem_addr, mem_wdata SHALL hold stable until mem_ready=1; requester inputs ignored.
REQ-009 BUSY_x with mem_ready=1: SHALL capture mem_rdata into x_rdata (loads/fetches only), pulse x_valid one cycle, drop mem_en and mem_we, return to IDLE.
REQ-010 Store completion: d_valid pulses; d_rdata SHALL keep previous value.
REQ-011 Minimum latency: request at edge N -> gnt during N..N+1, mem_ready at edge N+1 -> valid during N+1..N+2; one IDLE cycle between accesses.
REQ-012 mem_ready=1 in IDLE SHALL be ignored (no valid pulse, no state change).
REQ-013 Requester dropping req before gnt: no transaction, no counter change.
REQ-014 Requester SHALL hold req/addr/data until gnt; arbiter does not buffer unaccepted requests.
REQ-015 Ungranted requester waits indefinitely; no timeout.

Reset
REQ-016 reset=1 SHALL immediately force IDLE, starve counter 0, all outputs 0, regardless of clk.
REQ-017 reset during BUSY_x SHALL abort the access: no valid pulse, mem_en and mem_we deassert asynchronously; later mem_ready ignored.
REQ-018 First arbitration SHALL occur on first rising clk edge after reset deasserts.

Verification
REQ-019 Single fetch: if_req=1, if_addr=0x0010, mem_ready one cycle after mem_en, mem_rdata=0xA123 -> if_gnt pulse, mem_addr=0x0010, mem_we=0, if_valid pulse, if_rdata=0xA123.
REQ-020 Store: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0xBEEF, mem_ready after 3 cycles -> mem_we=1 held 3 cycles, d_valid pulse, d_rdata unchanged.
REQ-021 Contention: if_req and d_req held continuously, default parameter -> grant order D,D,D,IF,D,D,D,IF; counter returns to 0 after each IF grant.
REQ-022 Stall: mem_ready low 10 cycles in BUSY_D with inputs toggling -> mem_addr/mem_wdata/mem_we constant all 10 cycles.
REQ-023 Reset mid-access: reset pulse in BUSY_IF, mem_ready=1 afterwards -> mem_en=0 immediately, no if_valid, state IDLE.
REQ-024 Spurious ready: mem_ready=1 in IDLE, no requests -> no valid pulse, mem_en stays 0.
